// File: rtl/debug_bus_arbiter.sv
// -----------------------------------------------------------------------------
// debug_bus_arbiter
//
// Shares one peripheral/memory bus between the core (m2) and two
// session-style debug masters: the UART firmware loader (m0, highest priority)
// and the JTAG debug module (m1). A debug session stalls the core. When the
// session ends, the core is held in reset for RST_HOLD_CYCLES cycles so it
// restarts from the freshly written image.
//
// Ports:
//   clk_i, rst_ni                    clock, synchronous active-low reset
//   m0_req_i/we/addr/wdata, m0_rdata_o  UART loader session port
//   m1_req_i/we/addr/wdata, m1_rdata_o  JTAG session port
//   m2_req_i/we/addr/wdata, m2_gnt_o, m2_rdata_o  core per-access port
//   s_we_o/s_addr_o/s_wdata_o, s_rdata_i  shared slave bus
//   hold_o       core stall
//   core_rst_no  active-low core reset
//   owner_o      current owner / FSM state: 0 core, 1 m0, 2 m1, 3 none
//
// Handshake: m0/m1 requests are levels held for a whole session; ownership
// begins the cycle after the request is first sampled high and no handshake
// is returned. The core uses req/gnt: an access completes only in a cycle
// where m2_req_i and m2_gnt_o are both high; otherwise the core must retry.
// -----------------------------------------------------------------------------
module debug_bus_arbiter #(
  parameter int unsigned RST_HOLD_CYCLES = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic [31:0] m1_rdata_o,
  input  logic        m2_req_i,
  input  logic        m2_we_i,
  input  logic [31:0] m2_addr_i,
  input  logic [31:0] m2_wdata_i,
  output logic        m2_gnt_o,
  output logic [31:0] m2_rdata_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  input  logic [31:0] s_rdata_i,
  output logic        hold_o,
  output logic        core_rst_no,
  output logic [1:0]  owner_o
);

  // Encoding chosen so the state register doubles as the owner_o debug view.
  typedef enum logic [1:0] {
    S_CORE    = 2'd0,
    S_DBG0    = 2'd1,
    S_DBG1    = 2'd2,
    S_RESTART = 2'd3
  } state_t;

  localparam logic [7:0] RST_LOAD = 8'(RST_HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] rst_cnt_q, rst_cnt_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_CORE;
      rst_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    case (state_q)
      S_CORE: begin
        if (m0_req_i)      state_d = S_DBG0;
        else if (m1_req_i) state_d = S_DBG1;
      end
      // Sessions are never preempted; only the owner's own drop ends them.
      S_DBG0: begin
        if (!m0_req_i) begin
          state_d   = S_RESTART;
          rst_cnt_d = RST_LOAD;
        end
      end
      S_DBG1: begin
        if (!m1_req_i) begin
          state_d   = S_RESTART;
          rst_cnt_d = RST_LOAD;
        end
      end
      S_RESTART: begin
        // Counter is loaded with N-1 on entry, so the state lasts N cycles.
        // A pending debug request goes straight to its session, skipping
        // S_CORE, so a re-raised or queued request is not lost.
        if (rst_cnt_q == 8'd0) begin
          if (m0_req_i)      state_d = S_DBG0;
          else if (m1_req_i) state_d = S_DBG1;
          else               state_d = S_CORE;
        end else begin
          rst_cnt_d = rst_cnt_q - 8'd1;
        end
      end
      default: state_d = S_CORE;
    endcase
  end

  // Bus mux and Moore outputs, decoded from the registered state only.
  always_comb begin
    s_we_o      = 1'b0;
    s_addr_o    = 32'd0;
    s_wdata_o   = 32'd0;
    m0_rdata_o  = 32'd0;
    m1_rdata_o  = 32'd0;
    m2_rdata_o  = 32'd0;
    m2_gnt_o    = 1'b0;
    hold_o      = 1'b1;
    core_rst_no = 1'b1;
    case (state_q)
      S_CORE: begin
        s_we_o     = m2_we_i & m2_req_i;
        s_addr_o   = m2_addr_i;
        s_wdata_o  = m2_wdata_i;
        m2_gnt_o   = m2_req_i;
        m2_rdata_o = s_rdata_i;
        hold_o     = 1'b0;
      end
      S_DBG0: begin
        s_we_o     = m0_we_i;
        s_addr_o   = m0_addr_i;
        s_wdata_o  = m0_wdata_i;
        m0_rdata_o = s_rdata_i;
      end
      S_DBG1: begin
        s_we_o     = m1_we_i;
        s_addr_o   = m1_addr_i;
        s_wdata_o  = m1_wdata_i;
        m1_rdata_o = s_rdata_i;
      end
      S_RESTART: begin
        core_rst_no = 1'b0;
      end
      default: begin
        core_rst_no = 1'b1;
      end
    endcase
  end

  assign owner_o = state_q;

endmodule

// File: tb/tb_debug_bus_arbiter.sv
module tb_debug_bus_arbiter;

  localparam int N = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we, m2_req, m2_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, m2_addr, m2_wdata;
  logic [31:0] s_rdata;
  logic [31:0] m0_rdata, m1_rdata, m2_rdata, s_addr, s_wdata;
  logic        m2_gnt, s_we, hold, core_rst_n;
  logic [1:0]  owner;

  debug_bus_arbiter #(.RST_HOLD_CYCLES(N)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_rdata_o(m1_rdata),
    .m2_req_i(m2_req), .m2_we_i(m2_we), .m2_addr_i(m2_addr), .m2_wdata_i(m2_wdata),
    .m2_gnt_o(m2_gnt), .m2_rdata_o(m2_rdata),
    .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_rdata_i(s_rdata),
    .hold_o(hold), .core_rst_no(core_rst_n), .owner_o(owner)
  );

  wire [165:0] obs = {s_we, s_addr, s_wdata, m0_rdata, m1_rdata, m2_rdata,
                      m2_gnt, hold, core_rst_n, owner};

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  // Owner as an integer (0 core, 1 m0, 2 m1, 3 restarting) plus the number of
  // restart cycles still to run.
  int m_owner = 0;
  int m_left  = 0;

  task automatic model_step();
    if (!rst_n) begin
      m_owner = 0;
      m_left  = 0;
    end else if (m_owner == 0) begin
      if (m0_req) m_owner = 1;
      else if (m1_req) m_owner = 2;
    end else if (m_owner == 1 && !m0_req) begin
      m_owner = 3;
      m_left  = N;
    end else if (m_owner == 2 && !m1_req) begin
      m_owner = 3;
      m_left  = N;
    end else if (m_owner == 3) begin
      m_left = m_left - 1;
      if (m_left == 0) m_owner = m0_req ? 1 : (m1_req ? 2 : 0);
    end
  endtask

  function automatic logic [165:0] exp_vec();
    logic        we, gnt, hld, rn;
    logic [31:0] a, d, r0, r1, r2;
    we = 0; a = 0; d = 0; r0 = 0; r1 = 0; r2 = 0; gnt = 0; hld = 1; rn = 1;
    if (m_owner == 0) begin
      we = m2_we & m2_req; a = m2_addr; d = m2_wdata; r2 = s_rdata;
      gnt = m2_req; hld = 0;
    end else if (m_owner == 1) begin
      we = m0_we; a = m0_addr; d = m0_wdata; r0 = s_rdata;
    end else if (m_owner == 2) begin
      we = m1_we; a = m1_addr; d = m1_wdata; r1 = s_rdata;
    end else begin
      rn = 0;
    end
    return {we, a, d, r0, r1, r2, gnt, hld, rn, 2'(m_owner)};
  endfunction

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    rst_n = 1; m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    m2_req = 0; m2_we = 0; m2_addr = 0; m2_wdata = 0; s_rdata = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    tick();
    n_checks++;
    if ({hold, core_rst_n, owner} !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_outputs: hold/rstn/owner got %b, want 0100", {hold, core_rst_n, owner});
    end
    n_checks++;
    if ({m0_rdata, m1_rdata} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h, want 0", {m0_rdata, m1_rdata});
    end
    rst_n = 1;
  endtask

  task automatic test_core_access();
    m2_req = 1; m2_we = 1; m2_addr = 32'h3000_0008; m2_wdata = 32'h1B8;
    #1;
    n_checks++;
    if ({s_we, s_addr, s_wdata, m2_gnt, owner, hold} !== {1'b1, 32'h3000_0008, 32'h1B8, 1'b1, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL core_access: got we=%b addr=%h wd=%h gnt=%b own=%0d hold=%b", s_we, s_addr, s_wdata, m2_gnt, owner, hold);
    end
    tick();
  endtask

  task automatic test_m0_grant();
    m0_req = 1; m0_we = 1; m0_addr = 32'h3000_0000; m0_wdata = 32'h3;
    tick();
    n_checks++;
    if ({owner, hold, m2_gnt, s_we, s_addr, s_wdata} !== {2'd1, 1'b1, 1'b0, 1'b1, 32'h3000_0000, 32'h3}) begin
      n_fail++;
      $display("FAIL m0_grant: got own=%0d hold=%b gnt=%b we=%b addr=%h wd=%h", owner, hold, m2_gnt, s_we, s_addr, s_wdata);
    end
  endtask

  task automatic test_m0_read();
    m0_we = 0; m0_addr = 32'h3000_0010; s_rdata = 32'h5A;
    #1;
    n_checks++;
    if ({m0_rdata, m1_rdata, m2_rdata, s_we, s_addr} !== {32'h5A, 32'd0, 32'd0, 1'b0, 32'h3000_0010}) begin
      n_fail++;
      $display("FAIL m0_read: got r0=%h r1=%h r2=%h we=%b addr=%h", m0_rdata, m1_rdata, m2_rdata, s_we, s_addr);
    end
    tick();
  endtask

  task automatic test_restart();
    int low_cycles = 0;
    m0_req = 0; m0_we = 1;
    for (int i = 0; i < N; i++) begin
      tick();
      if (!core_rst_n) low_cycles++;
      n_checks++;
      if ({owner, core_rst_n, s_we, s_addr, s_wdata} !== {2'd3, 1'b0, 1'b0, 32'd0, 32'd0}) begin
        n_fail++;
        $display("FAIL restart_cycle_%0d: got own=%0d rstn=%b we=%b addr=%h", i, owner, core_rst_n, s_we, s_addr);
      end
    end
    tick();
    if (!core_rst_n) low_cycles++;
    n_checks++;
    if ({owner, hold, core_rst_n} !== {2'd0, 1'b0, 1'b1} || low_cycles != N) begin
      n_fail++;
      $display("FAIL restart_exit: got own=%0d hold=%b rstn=%b low=%0d, want 0/0/1/%0d", owner, hold, core_rst_n, low_cycles, N);
    end
  endtask

  task automatic test_simultaneous();
    m0_req = 1; m1_req = 1; m1_addr = 32'h4000_0000; m1_wdata = 32'h77; m1_we = 1;
    tick();
    n_checks++;
    if (owner !== 2'd1) begin
      n_fail++;
      $display("FAIL simul_m0_wins: got owner %0d, want 1", owner);
    end
    m0_req = 0;
    for (int i = 0; i < N; i++) begin
      tick();
      n_checks++;
      if (owner !== 2'd3) begin
        n_fail++;
        $display("FAIL simul_restart_%0d: got owner %0d, want 3", i, owner);
      end
    end
    tick();
    n_checks++;
    if ({owner, s_addr, s_wdata, hold} !== {2'd2, 32'h4000_0000, 32'h77, 1'b1}) begin
      n_fail++;
      $display("FAIL simul_m1_direct: got own=%0d addr=%h wd=%h hold=%b", owner, s_addr, s_wdata, hold);
    end
  endtask

  task automatic test_reset_mid_session();
    rst_n = 0;
    tick();
    n_checks++;
    if ({owner, hold, core_rst_n} !== {2'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL midreset: got own=%0d hold=%b rstn=%b, want 0/0/1", owner, hold, core_rst_n);
    end
    rst_n = 1;
    tick();
    n_checks++;
    if (owner !== 2'd2) begin
      n_fail++;
      $display("FAIL midreset_regrant: got owner %0d, want 2", owner);
    end
  endtask

  task automatic test_back_to_back();
    m1_req = 0;
    for (int i = 0; i < N; i++) begin
      tick();
      if (i == 2) m1_req = 1;
      n_checks++;
      if (owner !== 2'd3) begin
        n_fail++;
        $display("FAIL b2b_restart_%0d: got owner %0d, want 3", i, owner);
      end
    end
    tick();
    n_checks++;
    if (owner !== 2'd2) begin
      n_fail++;
      $display("FAIL b2b_regrant: got owner %0d, want 2", owner);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      // Sessions are long-lived levels: toggle rarely.
      if ($urandom_range(0, 15) == 0) m0_req = ~m0_req;
      if ($urandom_range(0, 11) == 0) m1_req = ~m1_req;
      rst_n    = ($urandom_range(0, 63) != 0);
      m0_we    = 1'($urandom); m0_addr = $urandom; m0_wdata = $urandom;
      m1_we    = 1'($urandom); m1_addr = $urandom; m1_wdata = $urandom;
      m2_req   = 1'($urandom); m2_we   = 1'($urandom);
      m2_addr  = $urandom;     m2_wdata = $urandom;
      s_rdata  = $urandom;
      #1;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: got %h want %h", c, obs, exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_core_access();
    test_m0_grant();
    test_m0_read();
    test_restart();
    test_simultaneous();
    test_reset_mid_session();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_bus_arbiter.md
# debug_bus_arbiter

Shares the single peripheral/memory bus between the core and two session-style debug masters: the UART firmware loader (m0) and the JTAG debug module (m1). A debug master holds its request high for a whole session, and gets the bus the cycle after it raises the request. While a session runs, the core is stalled. When the session ends, the core is held in reset for a programmable number of cycles so it restarts from the freshly written image.

## Interface
- RST_HOLD_CYCLES, 8: cycles core_rst_no stays low after a debug session ends; legal range 1..255.
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- m0_req_i  in  1  UART loader session request, level, highest priority
- m0_we_i / m0_addr_i / m0_wdata_i  in  1/32/32  UART loader bus outputs
- m0_rdata_o  out  32  read data to UART loader
- m1_req_i  in  1  JTAG session request, level
- m1_we_i / m1_addr_i / m1_wdata_i  in  1/32/32  JTAG bus outputs
- m1_rdata_o  out  32  read data to JTAG
- m2_req_i  in  1  core per-access request
- m2_we_i / m2_addr_i / m2_wdata_i  in  1/32/32  core bus outputs
- m2_gnt_o  out  1  core access granted this cycle
- m2_rdata_o  out  32  read data to core
- s_we_o / s_addr_o / s_wdata_o  out  1/32/32  shared bus to slaves
- s_rdata_i  in  32  slave read data, combinational from s_addr_o
- hold_o  out  1  core stall
- core_rst_no  out  1  active-low core reset, synchronous
- owner_o  out  2  current owner: 0 core, 1 m0, 2 m1, 3 none

## Operation
- The FSM has four states: S_CORE, S_DBG0, S_DBG1, S_RESTART. Encoding is free; owner_o reports it as 0/1/2/3.
- S_CORE:
  - Next state is S_DBG0 if m0_req_i is high.
  - Otherwise next state is S_DBG1 if m1_req_i is high.
  - Otherwise it stays in S_CORE.
- S_DBG0: stays while m0_req_i is high; when it drops, next state is S_RESTART. m1_req_i is ignored (no preemption).
- S_DBG1: stays while m1_req_i is high; when it drops, next state is S_RESTART. m0_req_i is ignored (no preemption).
- S_RESTART:
  - On entry, rst_cnt is loaded with RST_HOLD_CYCLES-1. It decrements each cycle spent in the state.
  - When rst_cnt==0, the next state is S_DBG0 if m0_req_i is high, else S_DBG1 if m1_req_i is high, else S_CORE.
  - rst_cnt width is 8 bits.
- Bus mux is combinational from the state register:
  - S_CORE: s_* = m2_*, with s_we_o = m2_we_i & m2_req_i. m2_gnt_o = m2_req_i. m2_rdata_o = s_rdata_i.
  - S_DBG0: s_* = m0_*. m0_rdata_o = s_rdata_i.
  - S_DBG1: s_* = m1_*. m1_rdata_o = s_rdata_i.
  - S_RESTART: s_we_o=0, s_addr_o=0, s_wdata_o=0.
  - Every non-owner rdata output is 0. m2_gnt_o is 0 outside S_CORE.
- Moore outputs, decoded from state:
  - hold_o = 1 in S_DBG0, S_DBG1 and S_RESTART.
  - core_rst_no = 0 only in S_RESTART.

## Timing
- Reset (rst_ni low at an edge) forces state to S_CORE and rst_cnt to 0. This applies mid-session and mid-restart.
- Output values after reset:
  - hold_o=0, core_rst_no=1, owner_o=0.
  - m0_rdata_o=0, m1_rdata_o=0.
  - s_*, m2_gnt_o and m2_rdata_o follow the core inputs combinationally.
- Grant latency:
  - A debug request sampled high at edge k gives ownership after edge k. The master's first registered access, launched at edge k, is therefore carried.
  - In that same window m2_gnt_o drops and hold_o rises.
- Session end:
  - A request sampled low at edge k puts the FSM in S_RESTART after k.
  - core_rst_no is low for exactly RST_HOLD_CYCLES cycles.
  - The core regains the bus after edge k+RST_HOLD_CYCLES.
- Simultaneous m0 and m1 requests: m0 wins and m1 waits. After m0 drops, m1 is granted straight from S_RESTART without returning to S_CORE.
- Back-to-back: a request that drops and re-rises during S_RESTART is re-granted at the end of restart.
- Core access in flight when a debug grant occurs:
  - It is not completed. m2_gnt_o is low and the core is stalled by hold_o.
  - The core retries after its reset.
- Read data is valid in the same cycle as s_addr_o. No extra cycle is added.

## Test plan
- Reset, then m2_req_i=1, m2_we_i=1, addr 0x30000008, wdata 0x1B8 -> s_we_o=1, s_addr_o=0x30000008, m2_gnt_o=1, owner_o=0, hold_o=0.
- m0_req_i rises with the m0 write addr 0x30000000, wdata 0x3 at the next edge -> at that edge owner_o=1, hold_o=1, m2_gnt_o=0, and the write appears on s_* in the same cycle.
- m0 read of addr 0x30000010 with s_rdata_i=0x5A -> m0_rdata_o=0x5A, m1_rdata_o=0, m2_rdata_o=0.
- m0_req_i drops, RST_HOLD_CYCLES=8 -> owner_o=3 and core_rst_no=0 for exactly 8 cycles, s_we_o=0 throughout, then owner_o=0, hold_o=0.
- m0_req_i and m1_req_i rise in the same cycle -> owner_o=1. After m0 drops: 8 restart cycles, then owner_o=2 with no S_CORE cycle in between.
- rst_ni low for one edge mid-S_DBG1 -> owner_o=0, hold_o=0, core_rst_no=1 next cycle. With m1_req_i still high at the following edge, owner_o=2.
